multi_retire_serializer: RTL
============================

Name: multi_retire_serializer

Overview:
Parametrised successor to the commit-port serializer. It buffers whole commit bundles (NrRetiredInstr uop slots plus shared cause/tval/priv) in one bundle FIFO and emits them one uop per beat over a valid/ready interface into trace_encoder. Slots with no retirement and no exception are skipped, unless legacy mode is selected. It adds CPU-side backpressure, a sticky overflow flag and a usage count.

Parameters:
NrRetiredInstr, 2, commit ports per cycle (>=1)
FifoDepth, 16, bundle FIFO depth (power of two, >=2)
SkipEmpty, 1, 1: emit only active slots; 0: emit every slot of every bundle

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
valid_i  in  1  commit bundle presented
iretire_i  in  [NrRetiredInstr][1]  per-slot retire
ilastsize_i  in  [NrRetiredInstr][ILASTSIZE_LEN]  per-slot last size
itype_i  in  [NrRetiredInstr][ITYPE_LEN]  per-slot type
iaddr_i  in  [NrRetiredInstr][XLEN]  per-slot address
cause_i  in  CAUSE_LEN  shared cause
tval_i  in  XLEN  shared tval
priv_i  in  PRIV_LEN  shared privilege
ready_o  out  1  FIFO not full
valid_o  out  1  beat valid
ready_i  in  1  encoder accepts beat
iretire_o  out  1  beat fields; widths as mure_pkg
ilastsize_o  out  ILASTSIZE_LEN
itype_o  out  ITYPE_LEN
iaddr_o  out  XLEN
cause_o  out  CAUSE_LEN
tval_o  out  XLEN
priv_o  out  PRIV_LEN
overflow_o  out  1  sticky: bundle dropped
usage_o  out  $clog2(FifoDepth)+1  bundles stored, including the head

Behaviour:
- Slot k is active when iretire_i[k]=1 or itype_i[k]!=0.
- Push when valid_i && any slot active && ready_o. If active && !ready_o, drop the bundle and set overflow_o=1 until reset. A simultaneous pop does not free space for that push, so ready_o=!full is purely registered state.
- valid_i with no active slot: no push and no flag.
- Entry: all slot fields, shared fields, and an active mask (all ones when SkipEmpty=0).
- Head holding register plus pending mask pend. FSM states:
  - IDLE: valid_o=0. If the FIFO is non-empty, load the head bundle, set pend=mask, go to EMIT.
  - EMIT: valid_o=1. The current slot is the lowest set bit of pend. Outputs = that slot's fields plus the shared fields.
  - On valid_o&&ready_i: clear that bit of pend.
  - If that was the last bit: pop the FIFO. If another bundle is available, load it in the same edge (no bubble); otherwise go to IDLE.
- SkipEmpty=0: inactive slots are emitted with iretire_o=0 and itype_o=0; order is slot 0 upward.
- Latency: a bundle pushed at edge t gives valid_o=1 after edge t+1 when the block is idle. With ready_i held 1, throughput is one beat per cycle.
- While valid_o && !ready_i, all outputs hold stable.
- Reset values: valid_o=0, every data output 0, overflow_o=0, usage_o=0, ready_o=1, state IDLE, pend=0.
- Reset mid-bundle: all state clears asynchronously and the remaining beats are discarded.
- Data outputs are 0 whenever valid_o=0.
- Pointer wrap-around: modulo FifoDepth; usage_o reaches FifoDepth exactly when full.

Test Plan:
1. NrRetiredInstr=2, SkipEmpty=1, ready_i=1; bundle iretire=11, iaddr={0x104,0x100} -> beat 0x100 then 0x104 on consecutive cycles, then valid_o=0.
2. Bundle iretire=10, iaddr[1]=0x2000 -> exactly one beat: iaddr_o=0x2000, iretire_o=1.
3. Two back-to-back bundles (11, then 01); ready_i low for 3 cycles in the middle -> outputs frozen while low; beats 0x100, 0x104, then the next bundle's slot-0 address with no idle cycle.
4. ready_i=0, push 16 bundles -> usage_o=16, ready_o=0; 17th bundle dropped, overflow_o=1 stays 1 after the FIFO drains.
5. SkipEmpty=0, bundle iretire=10 -> two beats: first iretire_o=0/itype_o=0, second iretire_o=1.
6. rst_ni low asynchronously after the first beat of a 2-slot bundle -> valid_o=0 immediately, usage_o=0, overflow_o=0; no further beats after release.

Source files
------------

// File: rtl/multi_retire_serializer_if.sv
// Commit-bundle input side and single-uop trace beat output side of the retire serializer.
// The slave modport is the serializer's view; master is the CPU/encoder side.
interface multi_retire_serializer_if #(
  parameter int NrRetiredInstr = 2,
  parameter int FifoDepth      = 16,
  parameter int XLEN           = 32,
  parameter int ITYPE_LEN      = 3,
  parameter int ILASTSIZE_LEN  = 1,
  parameter int CAUSE_LEN      = 5,
  parameter int PRIV_LEN       = 2
) ();
  localparam int UsageW = $clog2(FifoDepth) + 1;

  logic                                          valid_i;
  logic [NrRetiredInstr-1:0]                     iretire_i;
  logic [NrRetiredInstr-1:0][ILASTSIZE_LEN-1:0]  ilastsize_i;
  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]      itype_i;
  logic [NrRetiredInstr-1:0][XLEN-1:0]           iaddr_i;
  logic [CAUSE_LEN-1:0]                          cause_i;
  logic [XLEN-1:0]                               tval_i;
  logic [PRIV_LEN-1:0]                           priv_i;
  logic                                          ready_o;

  logic                                          valid_o;
  logic                                          ready_i;
  logic                                          iretire_o;
  logic [ILASTSIZE_LEN-1:0]                      ilastsize_o;
  logic [ITYPE_LEN-1:0]                          itype_o;
  logic [XLEN-1:0]                               iaddr_o;
  logic [CAUSE_LEN-1:0]                          cause_o;
  logic [XLEN-1:0]                               tval_o;
  logic [PRIV_LEN-1:0]                           priv_o;
  logic                                          overflow_o;
  logic [UsageW-1:0]                             usage_o;

  modport master (
    output valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i, cause_i, tval_i, priv_i, ready_i,
    input  ready_o, valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o,
           overflow_o, usage_o
  );

  modport slave (
    input  valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i, cause_i, tval_i, priv_i, ready_i,
    output ready_o, valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o,
           overflow_o, usage_o
  );
endinterface

// File: rtl/multi_retire_serializer.sv
// Buffers whole commit bundles in a FIFO and replays them one uop slot per beat
// to the trace encoder, skipping empty slots unless SkipEmpty is cleared.
module multi_retire_serializer #(
  parameter int NrRetiredInstr = 2,
  parameter int FifoDepth      = 16,
  parameter bit SkipEmpty      = 1'b1,
  parameter int XLEN           = 32,
  parameter int ITYPE_LEN      = 3,
  parameter int ILASTSIZE_LEN  = 1,
  parameter int CAUSE_LEN      = 5,
  parameter int PRIV_LEN       = 2
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  multi_retire_serializer_if.slave   bus
);
  localparam int PtrW   = $clog2(FifoDepth);
  localparam int UsageW = PtrW + 1;
  localparam int SlotW  = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

  typedef struct packed {
    logic [NrRetiredInstr-1:0]                     retire;
    logic [NrRetiredInstr-1:0][ILASTSIZE_LEN-1:0]  lastsize;
    logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]      itype;
    logic [NrRetiredInstr-1:0][XLEN-1:0]           iaddr;
    logic [CAUSE_LEN-1:0]                          cause;
    logic [XLEN-1:0]                               tval;
    logic [PRIV_LEN-1:0]                           priv;
    logic [NrRetiredInstr-1:0]                     mask;
  } entry_t;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                    state_reg, state_next;
  entry_t                    head_reg, head_next;
  logic [NrRetiredInstr-1:0] pend_reg, pend_next;
  logic [PtrW-1:0]           rd_ptr_reg, wr_ptr_reg;
  logic [UsageW-1:0]         count_reg;
  logic                      overflow_reg;

  entry_t                    mem [FifoDepth];
  entry_t                    wr_entry, rd_entry;
  logic [NrRetiredInstr-1:0] active;
  logic                      any_active, full, push, pop;
  logic [PtrW-1:0]           rd_sel;
  logic [SlotW-1:0]          cur_slot;
  logic [NrRetiredInstr-1:0] cur_onehot, pend_rest;

  for (genvar gi = 0; gi < NrRetiredInstr; gi++) begin : g_active
    assign active[gi] = bus.iretire_i[gi] | (|bus.itype_i[gi]);
  end

  assign any_active = |active;
  assign full       = (count_reg == UsageW'(FifoDepth));
  // Full is judged before any same-cycle pop so ready_o stays a pure register.
  assign push       = bus.valid_i && any_active && !full;

  always_comb begin
    wr_entry.retire   = bus.iretire_i;
    wr_entry.lastsize = bus.ilastsize_i;
    wr_entry.itype    = bus.itype_i;
    wr_entry.iaddr    = bus.iaddr_i;
    wr_entry.cause    = bus.cause_i;
    wr_entry.tval     = bus.tval_i;
    wr_entry.priv     = bus.priv_i;
    wr_entry.mask     = SkipEmpty ? active : '1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= wr_entry;
  end

  // In EMIT the FIFO head is already in head_reg, so the next bundle sits one slot beyond.
  assign rd_sel   = (state_reg == IDLE) ? rd_ptr_reg : rd_ptr_reg + PtrW'(1);
  assign rd_entry = mem[rd_sel];

  always_comb begin
    cur_slot = '0;
    for (int k = NrRetiredInstr - 1; k >= 0; k--) begin
      if (pend_reg[k]) cur_slot = SlotW'(k);
    end
  end

  assign cur_onehot = NrRetiredInstr'(1) << cur_slot;
  assign pend_rest  = pend_reg & ~cur_onehot;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    pend_next  = pend_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          head_next  = rd_entry;
          pend_next  = rd_entry.mask;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (bus.ready_i) begin
          pend_next = pend_rest;
          if (pend_rest == '0) begin
            pop = 1'b1;
            if (count_reg > UsageW'(1)) begin
              head_next = rd_entry;
              pend_next = rd_entry.mask;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      head_reg     <= '0;
      pend_reg     <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      head_reg   <= head_next;
      pend_reg   <= pend_next;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
      if (push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + UsageW'(1);
        2'b01:   count_reg <= count_reg - UsageW'(1);
        default: count_reg <= count_reg;
      endcase
      if (bus.valid_i && any_active && full) overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    bus.valid_o     = (state_reg == EMIT);
    bus.iretire_o   = 1'b0;
    bus.ilastsize_o = '0;
    bus.itype_o     = '0;
    bus.iaddr_o     = '0;
    bus.cause_o     = '0;
    bus.tval_o      = '0;
    bus.priv_o      = '0;
    if (state_reg == EMIT) begin
      bus.iretire_o   = head_reg.retire[cur_slot];
      bus.ilastsize_o = head_reg.lastsize[cur_slot];
      bus.itype_o     = head_reg.itype[cur_slot];
      bus.iaddr_o     = head_reg.iaddr[cur_slot];
      bus.cause_o     = head_reg.cause;
      bus.tval_o      = head_reg.tval;
      bus.priv_o      = head_reg.priv;
    end
  end

  assign bus.ready_o    = !full;
  assign bus.overflow_o = overflow_reg;
  assign bus.usage_o    = count_reg;
endmodule
